// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
// Write-side pointer and flag controller for the asynchronous FIFO.
// It turns producer write requests into the storage write enable and address.
// It brings the read-domain Gray pointer into wclk through two flops.
// From that pointer it derives the full, almost-full, fill-level and overflow status.
// It exports the registered Gray write pointer to the read domain.
//
// Ports
//   wclk          in   write-domain clock
//   RST           in   asynchronous active-low reset
//   winc          in   producer write request, one word per cycle
//   rptr_gray     in   read-domain Gray read pointer (asynchronous to wclk)
//   wovf_clr      in   synchronous clear of wovf
//   wclken        out  storage write enable, winc & ~wfull
//   waddr         out  storage write address
//   wptr_gray     out  registered Gray write pointer, to the read domain
//   wfull         out  registered full flag
//   walmost_full  out  registered almost-full flag
//   wcount        out  registered fill level seen from wclk, 0..DEPTH
//   wovf          out  sticky overflow flag (set wins over clear)
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  wclk,
  input  logic                  RST,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic                  wovf_clr,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  wovf
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  logic [ADDR_WIDTH:0] rq1;
  logic [ADDR_WIDTH:0] rq2;
  logic [ADDR_WIDTH:0] rbin_s;
  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] full_cmp;
  logic [ADDR_WIDTH:0] level_next;

  // Two-flop synchroniser: rptr_gray goes straight into rq1 with no logic in
  // front, so only one Gray bit can be in flight at a time.
  always_ff @(posedge wclk or negedge RST) begin
    if (!RST) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= rptr_gray;
      rq2 <= rq1;
    end
  end

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_s[i] = ^(rq2 >> i);
    end
  end

  assign wclken     = winc & ~wfull;
  assign waddr      = wbin[ADDR_WIDTH-1:0];
  assign wbin_next  = wbin + PW'(wclken);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the write pointer is a whole lap ahead of the read pointer.
  // In Gray code that is the top two bits inverted and the rest equal.
  assign full_cmp   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};

  // Modulo subtraction. A stale (older) read pointer only overstates the
  // level, so the flags stay pessimistic.
  assign level_next = wbin_next - rbin_s;

  always_ff @(posedge wclk or negedge RST) begin
    if (!RST) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      wovf         <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= (wgray_next == full_cmp);
      walmost_full <= (level_next >= AF_LEVEL);
      wcount       <= level_next;
      if (winc && wfull) begin
        wovf <= 1'b1;
      end else if (wovf_clr) begin
        wovf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side pointer and flag controller for the asynchronous FIFO, clocked by `wclk`. It sits directly upstream of the FIFO storage array. It turns producer write requests into the storage write enable and write address. It synchronises the read-domain Gray pointer into `wclk`, and from it generates full, almost-full, fill-level and overflow status. It exports the registered Gray write pointer to the read-domain controller.

## Interface
- `ADDR_WIDTH`, 3, storage address width; depth `DEPTH` = 2^ADDR_WIDTH = 8.
- `AF_MARGIN`, 2, `walmost_full` asserts when fill level ≥ `DEPTH` − `AF_MARGIN`; legal range 1..`DEPTH`−1.

Ports:
- `wclk`  in  1  write-domain clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `winc`  in  1  producer write request, one word per cycle.
- `rptr_gray`  in  ADDR_WIDTH+1  read-domain Gray read pointer; asynchronous to `wclk`.
- `wovf_clr`  in  1  synchronous clear of `wovf`.
- `wclken`  out  1  storage write enable; combinational: `winc` & ~`wfull`.
- `waddr`  out  ADDR_WIDTH  storage write address = `wbin[ADDR_WIDTH-1:0]`.
- `wptr_gray`  out  ADDR_WIDTH+1  registered Gray write pointer, to the read domain.
- `wfull`  out  1  registered full flag.
- `walmost_full`  out  1  registered almost-full flag.
- `wcount`  out  ADDR_WIDTH+1  registered fill level as seen in `wclk`, 0..`DEPTH`.
- `wovf`  out  1  sticky overflow flag.

## Operation
- Synchroniser: two flops `rq1` → `rq2` capture `rptr_gray` on `wclk`. No logic sits between `rptr_gray` and `rq1`.
- `rbin_s` = Gray-to-binary of `rq2` (combinational XOR prefix).
- Binary write counter `wbin` is ADDR_WIDTH+1 bits.
  - `wbin_next` = `wbin` + `wclken`.
  - Modulo 2^(ADDR_WIDTH+1) wrap (15 → 0 at defaults). No saturation.
- `wgray_next` = (`wbin_next` >> 1) ^ `wbin_next`. `wptr_gray` <= `wgray_next`, so exactly one bit changes per accepted write.
- Full: `wfull` <= (`wgray_next` == {~`rq2`[MSB], ~`rq2`[MSB-1], `rq2`[MSB-2:0]}).
- Level: `wcount` <= (`wbin_next` − `rbin_s`) mod 2^(ADDR_WIDTH+1). It never exceeds `DEPTH` for a legal reader.
- Almost full: `walmost_full` <= ((`wbin_next` − `rbin_s`) ≥ `DEPTH` − `AF_MARGIN`).
- Overflow: `wovf` <= 1 when `winc` & `wfull`.
  - `wovf_clr` clears it to 0.
  - Set has priority over clear in the same cycle.
- Write while full: the request is dropped. `wclken` = 0, and `wbin`/`wptr_gray` hold.
- Simultaneous write and read-pointer change: both are applied. The flags use the read pointer as of `rq2` that cycle.
- Flags are pessimistic.
  - `wfull` and `wcount` may lag read progress by the synchroniser delay.
  - They never under-report occupancy.

## Timing
- Reset (`RST` low, asynchronous) sets every register to 0: `rq1`, `rq2`, `wbin`, `wptr_gray`, `wfull`, `walmost_full`, `wcount`, `wovf`.
- Resulting output values in reset: `waddr` = 0, `wclken` = `winc`.
- Reset mid-operation: pointers return to 0 immediately. The read domain must be reset in the same event.
- Write latency: data is written at the same `wclk` edge where `wclken` = 1, at the current `waddr`. `waddr` advances after that edge.
- `wfull` timing:
  - Rises on the edge of the write that fills entry `DEPTH`, so no extra write is accepted.
  - Falls on the 3rd `wclk` edge after `rptr_gray` advances: 2 synchroniser edges plus 1 flag register.
- `wptr_gray` is valid 1 edge after the accepted write.
- `wcount` and `walmost_full` update on the same edge as `wfull`.

## Test plan
- Reset: hold `RST` = 0 with `winc` = 1 → all registered outputs 0 and `waddr` = 0. After release, the first write lands at `waddr` 0.
- Fill with `rptr_gray` = 0: 8 back-to-back `winc` pulses.
  - `waddr` runs 0..7.
  - `wptr_gray` runs 1,3,2,6,7,5,4,C.
  - `walmost_full` = 1 after the 6th write; `wfull` = 1 after the 8th; `wcount` = 8.
- Overflow: with full, pulse `winc` → `wclken` = 0, `waddr` holds at 0, `wovf` = 1. Then pulse `wovf_clr` → `wovf` = 0.
- Drain: from full, step `rptr_gray` 0 → 1 → `wfull` falls on the 3rd `wclk` edge and `wcount` = 7. The next write is accepted at `waddr` 0.
- Wrap-around: 40 writes with the reader echoing `wptr_gray` 4 cycles later → `wbin` wraps 15 → 0, `wfull` never asserts, and every consecutive `wptr_gray` pair differs in exactly 1 bit.
- Reset mid-fill: after 5 writes, pulse `RST` low for less than one cycle → `wbin`, `wcount` and `wptr_gray` are 0 immediately, and the next write uses `waddr` 0.
